// File: rtl/pie_encoder_if.sv
// Bit-stream handshake between the command builder (master) and the PIE encoder (slave).
//   in_dat  : command bit
//   in_vld  : in_dat valid
//   in_last : in_dat is the final bit of the frame
//   in_rdy  : encoder takes in_dat this cycle when in_vld=1
interface pie_encoder_if;
  logic in_dat;
  logic in_vld;
  logic in_last;
  logic in_rdy;

  modport master (
    output in_dat,
    output in_vld,
    output in_last,
    input  in_rdy
  );

  modport slave (
    input  in_dat,
    input  in_vld,
    input  in_last,
    output in_rdy
  );
endinterface

// File: rtl/pie_encoder.sv
// Gen2 forward-link PIE encoder. Turns a handshaked stream of command bits into a 1-bit
// carrier-enable waveform: delimiter, data-0, RTcal, optional TRcal, then one PIE symbol
// per command bit. Every symbol ends with a PW_TICKS-long low pulse.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a frame (sampled only while idle)
//   preamble_sel : latched on start; 1 = preamble (with TRcal), 0 = frame-sync
//   bits         : command bit stream (slave side of pie_encoder_if)
//   tx_mod       : 1 = full carrier, 0 = attenuated
//   busy         : frame in progress
//   done         : one-cycle pulse, frame completed normally
//   underrun     : one-cycle pulse, frame aborted for lack of a bit
module pie_encoder #(
  parameter int unsigned TARI_TICKS  = 8,
  parameter int unsigned DATA1_TICKS = 14,
  parameter int unsigned PW_TICKS    = 4,
  parameter int unsigned DELIM_TICKS = 6,
  parameter int unsigned TRCAL_TICKS = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          preamble_sel,
  pie_encoder_if.slave  bits,
  output logic          tx_mod,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  localparam int unsigned RtcalTicks = TARI_TICKS + DATA1_TICKS;
  localparam int unsigned MaxCal     = (RtcalTicks > TRCAL_TICKS) ? RtcalTicks : TRCAL_TICKS;
  localparam int unsigned MaxLen     = (MaxCal > DELIM_TICKS) ? MaxCal : DELIM_TICKS;
  localparam int unsigned CntW       = $clog2(MaxLen) + 1;

  localparam logic [CntW-1:0] LenTari  = CntW'(TARI_TICKS);
  localparam logic [CntW-1:0] LenData1 = CntW'(DATA1_TICKS);
  localparam logic [CntW-1:0] LenRtcal = CntW'(RtcalTicks);
  localparam logic [CntW-1:0] LenTrcal = CntW'(TRCAL_TICKS);
  localparam logic [CntW-1:0] LenDelim = CntW'(DELIM_TICKS);
  localparam logic [CntW-1:0] LenPw    = CntW'(PW_TICKS);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StDelim,
    StData0,
    StRtcal,
    StTrcal,
    StData
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;     // tick index within the current symbol
  logic [CntW-1:0] len_q, len_d;     // length of the current symbol
  logic            pre_q, pre_d;
  logic            last_q, last_d;   // current data symbol carries in_last
  logic            in_rdy_q, in_rdy_d;
  logic            tx_mod_q, tx_mod_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;

  logic            final_tick;
  logic            final_tick_d;
  logic            fetch;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    pre_d      = pre_q;
    last_d     = last_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    fetch      = 1'b0;
    final_tick = (cnt_q == (len_q - CntOne));

    if (state_q == StIdle) begin
      if (start) begin
        state_d = StDelim;
        cnt_d   = '0;
        len_d   = LenDelim;
        pre_d   = preamble_sel;
      end
    end else if (!final_tick) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        StDelim: begin
          state_d = StData0;
          len_d   = LenTari;
        end
        StData0: begin
          state_d = StRtcal;
          len_d   = LenRtcal;
        end
        StRtcal: begin
          if (pre_q) begin
            state_d = StTrcal;
            len_d   = LenTrcal;
          end else begin
            fetch = 1'b1;
          end
        end
        StTrcal: fetch = 1'b1;
        StData: begin
          if (last_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            fetch = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // fetch coincides with in_rdy_q being high; a missing bit aborts the frame.
    if (fetch) begin
      if (bits.in_vld) begin
        state_d = StData;
        len_d   = bits.in_dat ? LenData1 : LenTari;
        last_d  = bits.in_last;
      end else begin
        state_d    = StIdle;
        underrun_d = 1'b1;
      end
    end
  end

  // Registered outputs are decoded from the next state so they line up with the counter.
  always_comb begin
    final_tick_d = (cnt_d == (len_d - CntOne));
    in_rdy_d     = final_tick_d && (((state_d == StRtcal) && !pre_d) ||
                                    (state_d == StTrcal) ||
                                    ((state_d == StData) && !last_d));
    busy_d       = (state_d != StIdle);
    unique case (state_d)
      StIdle:  tx_mod_d = 1'b1;
      StDelim: tx_mod_d = 1'b0;
      default: tx_mod_d = (cnt_d < (len_d - LenPw));
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= LenDelim;
      pre_q      <= 1'b0;
      last_q     <= 1'b0;
      in_rdy_q   <= 1'b0;
      tx_mod_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      pre_q      <= pre_d;
      last_q     <= last_d;
      in_rdy_q   <= in_rdy_d;
      tx_mod_q   <= tx_mod_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign bits.in_rdy = in_rdy_q;
  assign tx_mod      = tx_mod_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pie_encoder.sv
module tb_pie_encoder;

  localparam int T_A  = 8;
  localparam int D1_A = 14;
  localparam int PW_A = 4;
  localparam int T_B  = 12;
  localparam int D1_B = 24;
  localparam int PW_B = 6;
  localparam int DL   = 6;
  localparam int TR   = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, preamble_sel, in_dat, in_vld, in_last;
  logic tx_a, busy_a, done_a, un_a, rdy_a;
  logic tx_b, busy_b, done_b, un_b, rdy_b;

  pie_encoder_if bus_a ();
  pie_encoder_if bus_b ();

  assign bus_a.in_dat  = in_dat;
  assign bus_a.in_vld  = in_vld;
  assign bus_a.in_last = in_last;
  assign rdy_a         = bus_a.in_rdy;
  assign bus_b.in_dat  = in_dat;
  assign bus_b.in_vld  = in_vld;
  assign bus_b.in_last = in_last;
  assign rdy_b         = bus_b.in_rdy;

  pie_encoder #(
    .TARI_TICKS (T_A),
    .DATA1_TICKS(D1_A),
    .PW_TICKS   (PW_A),
    .DELIM_TICKS(DL),
    .TRCAL_TICKS(TR)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .preamble_sel(preamble_sel),
    .bits        (bus_a),
    .tx_mod      (tx_a),
    .busy        (busy_a),
    .done        (done_a),
    .underrun    (un_a)
  );

  pie_encoder #(
    .TARI_TICKS (T_B),
    .DATA1_TICKS(D1_B),
    .PW_TICKS   (PW_B),
    .DELIM_TICKS(DL),
    .TRCAL_TICKS(TR)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .preamble_sel(preamble_sel),
    .bits        (bus_b),
    .tx_mod      (tx_b),
    .busy        (busy_b),
    .done        (done_b),
    .underrun    (un_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model output: one entry per cycle after the start cycle.
  bit e_tx[$], e_busy[$], e_rdy[$], e_done[$], e_un[$];
  bit o_tx[0:2047], o_busy[0:2047], o_rdy[0:2047], o_done[0:2047], o_un[0:2047];
  int o_len;
  int accepted;
  bit frame_bits[64];
  int frame_n;

  typedef struct {
    int scen;
    int cyc;
    bit tx;
    bit busy;
    bit rdy;
    bit done;
  } cp_t;
  cp_t tab[32];
  int  ntab;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got tx/busy/rdy/done/underrun=%b, required %b", name, act, req);
    end
  endtask

  task automatic push_cyc(input bit tx, input bit b, input bit r, input bit d, input bit u);
    e_tx.push_back(tx);
    e_busy.push_back(b);
    e_rdy.push_back(r);
    e_done.push_back(d);
    e_un.push_back(u);
  endtask

  // One PIE symbol: high, then a pw-long low pulse; in_rdy optionally on the last tick.
  task automatic push_sym(input int len, input int pw, input bit rdy_end);
    for (int t = 0; t < len; t++) push_cyc(t < len - pw, 1'b1, rdy_end && (t == len - 1), 0, 0);
  endtask

  task automatic build_model(input bit sel, input bit pre, input int un_at);
    int tari, d1, pw;
    bit aborted;
    tari = sel ? T_B : T_A;
    d1   = sel ? D1_B : D1_A;
    pw   = sel ? PW_B : PW_A;
    e_tx.delete(); e_busy.delete(); e_rdy.delete(); e_done.delete(); e_un.delete();
    for (int i = 0; i < DL; i++) push_cyc(0, 1, 0, 0, 0);
    push_sym(tari, pw, 0);
    push_sym(tari + d1, pw, !pre);
    if (pre) push_sym(TR, pw, 1);
    aborted = 0;
    for (int i = 0; i < frame_n; i++) begin
      if (i == un_at) begin
        aborted = 1;
        break;
      end
      push_sym(frame_bits[i] ? d1 : tari, pw, i != frame_n - 1);
    end
    if (aborted) push_cyc(1, 0, 0, 0, 1);
    else         push_cyc(1, 0, 0, 1, 0);
  endtask

  // Caller sits #1 after a posedge with the selected DUT idle; that cycle is cycle 0.
  task automatic run_frame(input bit sel, input bit pre, input int un_at, input int extra_start,
                           input string tag);
    int ptr;
    logic [4:0] act, req;
    build_model(sel, pre, un_at);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    preamble_sel = pre;
    in_vld = 1'b0;
    ptr = 0;
    accepted = 0;
    o_tx[0] = 1'b1;
    o_len = e_tx.size();
    for (int k = 1; k <= o_len; k++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      if (k == extra_start) begin
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        preamble_sel = !pre;
      end
      o_tx[k]   = sel ? tx_b : tx_a;
      o_busy[k] = sel ? busy_b : busy_a;
      o_rdy[k]  = sel ? rdy_b : rdy_a;
      o_done[k] = sel ? done_b : done_a;
      o_un[k]   = sel ? un_b : un_a;
      act = {o_tx[k], o_busy[k], o_rdy[k], o_done[k], o_un[k]};
      req = {e_tx[k-1], e_busy[k-1], e_rdy[k-1], e_done[k-1], e_un[k-1]};
      check5($sformatf("%s cycle %0d", tag, k), act, req);
      if (ptr < frame_n && ptr != un_at) begin
        in_vld  = 1'b1;
        in_dat  = frame_bits[ptr];
        in_last = (ptr == frame_n - 1);
      end else begin
        in_vld = 1'b0;
      end
      if (o_rdy[k] && in_vld) begin
        ptr++;
        accepted++;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    in_vld  = 1'b0;
  endtask

  task automatic check_table(input int scen, input string tag);
    for (int i = 0; i < ntab; i++) begin
      if (tab[i].scen == scen) begin
        check5($sformatf("%s table cycle %0d", tag, tab[i].cyc),
               {o_tx[tab[i].cyc], o_busy[tab[i].cyc], o_rdy[tab[i].cyc], o_done[tab[i].cyc], 1'b0},
               {tab[i].tx, tab[i].busy, tab[i].rdy, tab[i].done, 1'b0});
      end
    end
  endtask

  // Decode the recorded sweep waveform from its edges alone.
  task automatic decode_sweep(input bit pre, input string tag);
    int falls[$];
    int ncal, w, k;
    ncal = pre ? 4 : 3;
    for (int j = 1; j <= o_len; j++) if (!o_tx[j] && o_tx[j-1]) falls.push_back(j);
    check($sformatf("%s low pulse count", tag), falls.size(), ncal + frame_n);
    if (falls.size() == ncal + frame_n) begin
      for (int j = 0; j < falls.size(); j++) begin
        w = 0;
        k = falls[j];
        while (k <= o_len && !o_tx[k]) begin
          w++;
          k++;
        end
        check($sformatf("%s low width %0d", tag, j), w, (j == 0) ? DL : PW_B);
      end
      for (int i = 0; i < frame_n; i++)
        check($sformatf("%s bit %0d interval", tag, i), falls[ncal + i] - falls[ncal + i - 1],
              frame_bits[i] ? D1_B : T_B);
    end
    check($sformatf("%s accepted bits", tag), accepted, frame_n);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    ntab = 0;
    tab[ntab++] = '{0, 1, 0, 1, 0, 0};
    tab[ntab++] = '{0, 6, 0, 1, 0, 0};
    tab[ntab++] = '{0, 7, 1, 1, 0, 0};
    tab[ntab++] = '{0, 10, 1, 1, 0, 0};
    tab[ntab++] = '{0, 11, 0, 1, 0, 0};
    tab[ntab++] = '{0, 14, 0, 1, 0, 0};
    tab[ntab++] = '{0, 15, 1, 1, 0, 0};
    tab[ntab++] = '{0, 32, 1, 1, 0, 0};
    tab[ntab++] = '{0, 33, 0, 1, 0, 0};
    tab[ntab++] = '{0, 36, 0, 1, 1, 0};
    tab[ntab++] = '{0, 37, 1, 1, 0, 0};
    tab[ntab++] = '{0, 46, 1, 1, 0, 0};
    tab[ntab++] = '{0, 47, 0, 1, 0, 0};
    tab[ntab++] = '{0, 50, 0, 1, 1, 0};
    tab[ntab++] = '{0, 51, 1, 1, 0, 0};
    tab[ntab++] = '{0, 54, 1, 1, 0, 0};
    tab[ntab++] = '{0, 55, 0, 1, 0, 0};
    tab[ntab++] = '{0, 58, 0, 1, 0, 0};
    tab[ntab++] = '{0, 59, 1, 0, 0, 1};
    tab[ntab++] = '{1, 36, 0, 1, 0, 0};
    tab[ntab++] = '{1, 37, 1, 1, 0, 0};
    tab[ntab++] = '{1, 72, 1, 1, 0, 0};
    tab[ntab++] = '{1, 73, 0, 1, 0, 0};
    tab[ntab++] = '{1, 76, 0, 1, 1, 0};
    tab[ntab++] = '{1, 77, 1, 1, 0, 0};
    tab[ntab++] = '{1, 80, 1, 1, 0, 0};
    tab[ntab++] = '{1, 81, 0, 1, 0, 0};
    tab[ntab++] = '{1, 84, 0, 1, 0, 0};
    tab[ntab++] = '{1, 85, 1, 0, 0, 1};

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    preamble_sel = 1'b0;
    in_dat = 1'b0;
    in_vld = 1'b0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check5("reset dut_a", {tx_a, busy_a, rdy_a, done_a, un_a}, 5'b10000);
    check5("reset dut_b", {tx_b, busy_b, rdy_b, done_b, un_b}, 5'b10000);
    rst = 1'b0;
    step();
    check5("idle after reset", {tx_a, busy_a, rdy_a, done_a, un_a}, 5'b10000);

    // Frame-sync, bits 1,0; then again from the done cycle with a stray start at cycle 20.
    frame_n = 2;
    frame_bits[0] = 1'b1;
    frame_bits[1] = 1'b0;
    run_frame(0, 0, -1, -1, "fs10");
    check_table(0, "fs10");
    run_frame(0, 0, -1, 20, "fs10_restart");
    check_table(0, "fs10_restart");
    step();
    check("done pulse width", done_a, 0);

    // Preamble with a single data-0 bit.
    frame_n = 1;
    frame_bits[0] = 1'b0;
    run_frame(0, 1, -1, -1, "pre0");
    check_table(1, "pre0");

    // Underrun at the first fetch.
    step();
    frame_n = 2;
    frame_bits[0] = 1'b1;
    frame_bits[1] = 1'b0;
    run_frame(0, 0, 0, -1, "underrun");
    check("underrun cycle36 tx", o_tx[36], 0);
    check("underrun cycle37 flag", o_un[37], 1);
    check("underrun cycle37 tx", o_tx[37], 1);
    step();
    check5("after underrun", {tx_a, busy_a, rdy_a, done_a, un_a}, 5'b10000);

    // Reset in the middle of the data-0 low pulse.
    start_a = 1'b1;
    preamble_sel = 1'b0;
    in_vld = 1'b1;
    in_dat = 1'b1;
    in_last = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      start_a = 1'b0;
    end
    check("pre-reset cycle12 tx", tx_a, 0);
    rst = 1'b1;
    step();
    check5("mid-frame reset", {tx_a, busy_a, rdy_a, done_a, un_a}, 5'b10000);
    rst = 1'b0;
    in_vld = 1'b0;
    step();
    check5("after mid-frame reset", {tx_a, busy_a, rdy_a, done_a, un_a}, 5'b10000);

    // Random frames on the default encoder, the last one with an underrun.
    for (int r = 0; r < 6; r++) begin
      int un_at;
      bit pre;
      pre = 1'($urandom_range(0, 1));
      frame_n = $urandom_range(1, 8);
      for (int i = 0; i < frame_n; i++) frame_bits[i] = 1'($urandom_range(0, 1));
      un_at = (r == 5) ? int'($urandom_range(0, frame_n - 1)) : -1;
      run_frame(0, pre, un_at, -1, $sformatf("rand%0d", r));
      check($sformatf("rand%0d accepted", r), accepted, (un_at < 0) ? frame_n : un_at);
      v = $urandom_range(0, 2);
      repeat (v) step();
    end

    // Parameter sweep on the 12/24/6 encoder with 32-bit frames.
    for (int r = 0; r < 3; r++) begin
      bit pre;
      logic [31:0] word;
      pre = 1'($urandom_range(0, 1));
      word = $urandom;
      frame_n = 32;
      for (int i = 0; i < 32; i++) frame_bits[i] = word[i];
      run_frame(1, pre, -1, -1, $sformatf("sweep%0d", r));
      decode_sweep(pre, $sformatf("sweep%0d", r));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pie_encoder.md
Name: pie_encoder

Overview:
Reader-to-tag transmit encoder for the Gen2 forward link. It turns a handshaked stream of command bits into a PIE-modulated 1-bit carrier-enable signal, with every symbol timed in clock ticks. It prepends a delimiter plus either a preamble (data-0, RTcal, TRcal) or a frame-sync (data-0, RTcal). It sits between the command builder and the DAC/modulator front end, and is the transmit counterpart of the receive-side bit detection.

Parameters:
TARI_TICKS, 8, data-0 symbol length in clk ticks
DATA1_TICKS, 14, data-1 symbol length in ticks; must satisfy TARI_TICKS < DATA1_TICKS <= 2*TARI_TICKS
PW_TICKS, 4, low-pulse width ending every symbol; must satisfy 0 < PW_TICKS < TARI_TICKS
DELIM_TICKS, 6, delimiter low time in ticks
TRCAL_TICKS, 40, TRcal symbol length in ticks; must be > PW_TICKS
RTcal length is fixed at TARI_TICKS+DATA1_TICKS. The internal counter width is $clog2 of the largest length plus 1.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
preamble_sel  in  1  latched on start; 1 = preamble (with TRcal), 0 = frame-sync
in_dat  in  1  command bit
in_vld  in  1  in_dat valid
in_last  in  1  qualifies in_dat as the final bit of the frame
in_rdy  out  1  encoder takes in_dat this cycle when in_vld=1
tx_mod  out  1  1 = full carrier, 0 = attenuated (PIE low)
busy  out  1  frame in progress
done  out  1  one-cycle pulse: frame completed normally
underrun  out  1  one-cycle pulse: frame aborted because no bit was available

Behaviour:
- Reset values: tx_mod=1, busy=0, in_rdy=0, done=0, underrun=0, state=IDLE. Reset mid-frame returns to IDLE on the next edge with tx_mod=1. No done or underrun pulse is generated for a reset.
- States: IDLE, DELIM, DATA0, RTCAL, TRCAL, DATA.
- Symbol shape (all non-delimiter symbols) of length L: ticks 0..L-PW_TICKS-1 have tx_mod=1; ticks L-PW_TICKS..L-1 have tx_mod=0. The delimiter is DELIM_TICKS ticks of tx_mod=0.
- IDLE: tx_mod=1, busy=0. When start=1, latch preamble_sel and enter DELIM. The first delimiter tick appears in the cycle after start, and busy rises in that same cycle. start is ignored while busy.
- Sequence: DELIM -> DATA0 (L=TARI_TICKS) -> RTCAL (L=TARI_TICKS+DATA1_TICKS) -> TRCAL (L=TRCAL_TICKS, only if preamble_sel=1) -> DATA. All symbols are back-to-back with no gap ticks.
- Bit fetch: in_rdy=1 only during the final tick of the last calibration symbol (RTCAL or TRCAL), and during the final tick of each DATA symbol whose bit did not carry in_last. The transfer happens when in_rdy & in_vld. The accepted bit sets the next symbol length (0 -> TARI_TICKS, 1 -> DATA1_TICKS), and in_last is stored with it.
- Underrun: if in_rdy=1 and in_vld=0, the current symbol still completes its final tick. The next cycle is IDLE with tx_mod=1, busy=0 and underrun=1 for one cycle. The frame is not resumed.
- End of frame: after the final tick of the DATA symbol flagged in_last, the next cycle is IDLE with tx_mod=1, busy=0 and done=1 for one cycle. A new start may be accepted in that same cycle.
- in_rdy is never asserted in IDLE, DELIM or DATA0. The stall-free contract requires the upstream to present valid data whenever in_rdy is high.
- Outputs are registered. tx_mod reflects the current tick with no added pipeline delay relative to the counter.

Test Plan:
- Frame-sync, bits 1,0 (0 flagged last), in_vld held high, start at cycle 0 -> tx_mod low 1-6, high 7-10, low 11-14, high 15-32, low 33-36, in_rdy at 36, high 37-46, low 47-50, in_rdy at 50, high 51-54, low 55-58; done=1 and busy=0 at 59.
- Preamble, single bit 0 last -> same as above through cycle 36, then TRcal high 37-72, low 73-76, in_rdy at 76, data-0 77-84, done at 85.
- Underrun: frame-sync with in_vld=0 at cycle 36 -> cycle 36 low as normal; underrun=1 and tx_mod=1 at 37; no done pulse.
- start asserted at cycle 20 during an active frame -> ignored, waveform identical to the first scenario. start on the done cycle (59) -> new delimiter begins at 60.
- rst asserted at cycle 12 (mid data-0 low) -> at cycle 13 tx_mod=1, busy=0, in_rdy=0, with no done or underrun pulse.
- Parameter sweep TARI_TICKS=12, DATA1_TICKS=24, PW_TICKS=6: random 32-bit frames -> the decoded low-to-low intervals match 12/24 ticks per bit, every low pulse is exactly 6 ticks, and the count of accepted bits equals the count of symbols.
